// File: rtl/dispatch_skid_buffer.sv
// ============================================================================
// dispatch_skid_buffer
// ----------------------------------------------------------------------------
// Two-entry skid buffer between the instruction buffer and rename. A complete
// dispatch bundle (four decoded packets plus its branch count) is captured
// from the buffer head and presented to rename one cycle later. A second
// (SKID) entry absorbs the bundle that was already in flight when rename
// stalled. This lets the back-pressure to the instruction buffer come
// straight from a flop, with no combinational path from renameStall_i.
//
// Optional feature (macro DISPATCH_BRCHK_EN):
//   When defined, the freeBranchTags_i port exists and the head bundle is only
//   offered to rename when its branch count fits in the free branch tags.
//   When not defined, the head bundle is offered whenever the buffer is
//   non-empty.
//
// Ports
//   clk               in   1      clock
//   reset             in   1      synchronous, active-high reset
//   flush_i           in   1      control-misprediction flush (drops both entries)
//   bufReady_i        in   1      instruction buffer holds a full bundle
//   bufPacket0_i..3_i in   PKT_W  bundle slots 0-3 from the buffer head
//   bufBranchCount_i  in   BRC_W  branches in the incoming bundle
//   bufStall_o        out  1      registered back-pressure to the buffer
//   renameStall_i     in   1      rename cannot accept this cycle
//   valid_o           out  1      head bundle valid
//   packet0_o..3_o    out  PKT_W  head bundle slots 0-3
//   branchCount_o     out  BRC_W  branches in the head bundle
//   freeBranchTags_i  in   BRC_W  free branch tags (DISPATCH_BRCHK_EN only)
// ============================================================================

// Fallback widths so the block elaborates standalone; the processor's
// configuration header overrides these when it is included first.
`ifndef SIZE_SPECIAL_REG
`define SIZE_SPECIAL_REG 32
`endif
`ifndef LDST_TYPES_LOG
`define LDST_TYPES_LOG 2
`endif
`ifndef INST_TYPES_LOG
`define INST_TYPES_LOG 2
`endif
`ifndef SIZE_IMMEDIATE
`define SIZE_IMMEDIATE 16
`endif
`ifndef SIZE_RMT_LOG
`define SIZE_RMT_LOG 6
`endif
`ifndef SIZE_OPCODE_I
`define SIZE_OPCODE_I 8
`endif
`ifndef SIZE_PC
`define SIZE_PC 32
`endif
`ifndef SIZE_CTI_LOG
`define SIZE_CTI_LOG 4
`endif
`ifndef BRANCH_COUNT
`define BRANCH_COUNT 4
`endif

module dispatch_skid_buffer #(
   parameter int PKT_W = 2*`SIZE_SPECIAL_REG + 3 + `LDST_TYPES_LOG + `INST_TYPES_LOG
                         + `SIZE_IMMEDIATE + 1 + 3*`SIZE_RMT_LOG + 3 + `SIZE_OPCODE_I
                         + 2*`SIZE_PC + `SIZE_CTI_LOG + 1,
   parameter int BRC_W = `BRANCH_COUNT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush_i,
   input  logic             bufReady_i,
   input  logic [PKT_W-1:0] bufPacket0_i,
   input  logic [PKT_W-1:0] bufPacket1_i,
   input  logic [PKT_W-1:0] bufPacket2_i,
   input  logic [PKT_W-1:0] bufPacket3_i,
   input  logic [BRC_W-1:0] bufBranchCount_i,
   output logic             bufStall_o,
   input  logic             renameStall_i,
   output logic             valid_o,
   output logic [PKT_W-1:0] packet0_o,
   output logic [PKT_W-1:0] packet1_o,
   output logic [PKT_W-1:0] packet2_o,
   output logic [PKT_W-1:0] packet3_o,
`ifdef DISPATCH_BRCHK_EN
   input  logic [BRC_W-1:0] freeBranchTags_i,
`endif
   output logic [BRC_W-1:0] branchCount_o
);

   localparam int SLOTS = 4;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic               stall_q;

   logic [PKT_W-1:0]   in_pkt   [SLOTS];
   logic [PKT_W-1:0]   head_pkt_q [SLOTS];
   logic [PKT_W-1:0]   skid_pkt_q [SLOTS];
   logic [BRC_W-1:0]   head_bc_q;
   logic [BRC_W-1:0]   skid_bc_q;

   // Head-entry load controls: load from the input bundle or promote SKID.
   logic               head_load_in;
   logic               head_load_skid;
   logic               skid_load_in;

   logic               head_ok;
   logic               valid;
   logic               accept;
   logic               consume;

   assign in_pkt[0] = bufPacket0_i;
   assign in_pkt[1] = bufPacket1_i;
   assign in_pkt[2] = bufPacket2_i;
   assign in_pkt[3] = bufPacket3_i;

   // ------------------------------------------------------------------------
   // Dispatch qualification
   // ------------------------------------------------------------------------
`ifdef DISPATCH_BRCHK_EN
   // Holding HEAD while the compare fails is the same as a rename stall:
   // valid drops, so consume cannot fire and the FSM keeps the entry.
   assign head_ok = (head_bc_q <= freeBranchTags_i);
`else
   assign head_ok = 1'b1;
`endif

   assign valid   = (state_q != ST_EMPTY) & head_ok;
   // stall_q is 1 exactly in TWO, so TWO never sees an accept.
   assign accept  = bufReady_i & ~stall_q & ~flush_i;
   assign consume = valid & ~renameStall_i;

   // ------------------------------------------------------------------------
   // Occupancy FSM: next state and entry load strobes
   // ------------------------------------------------------------------------
   always_comb begin
      state_d        = state_q;
      head_load_in   = 1'b0;
      head_load_skid = 1'b0;
      skid_load_in   = 1'b0;

      if (flush_i) begin
         state_d = ST_EMPTY;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  state_d      = ST_ONE;
                  head_load_in = 1'b1;
               end
            end
            ST_ONE: begin
               if (accept && consume) begin
                  // Head leaves and is replaced in the same cycle.
                  head_load_in = 1'b1;
               end else if (accept) begin
                  state_d      = ST_TWO;
                  skid_load_in = 1'b1;
               end else if (consume) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (consume) begin
                  state_d        = ST_ONE;
                  head_load_skid = 1'b1;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_EMPTY;
         stall_q <= 1'b0;
      end else begin
         state_q <= state_d;
         // Registered copy of "next state is TWO": equals (state_q == ST_TWO).
         stall_q <= (state_d == ST_TWO);
      end
   end

   // ------------------------------------------------------------------------
   // Entry storage, one register pair per packet slot
   // ------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
         always_ff @(posedge clk) begin
            if (reset) begin
               head_pkt_q[gi] <= '0;
               skid_pkt_q[gi] <= '0;
            end else begin
               if (head_load_in) begin
                  head_pkt_q[gi] <= in_pkt[gi];
               end else if (head_load_skid) begin
                  head_pkt_q[gi] <= skid_pkt_q[gi];
               end
               if (skid_load_in) begin
                  skid_pkt_q[gi] <= in_pkt[gi];
               end
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         head_bc_q <= '0;
         skid_bc_q <= '0;
      end else begin
         if (head_load_in) begin
            head_bc_q <= bufBranchCount_i;
         end else if (head_load_skid) begin
            head_bc_q <= skid_bc_q;
         end
         if (skid_load_in) begin
            skid_bc_q <= bufBranchCount_i;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bufStall_o    = stall_q;
   assign valid_o       = valid;
   assign packet0_o     = head_pkt_q[0];
   assign packet1_o     = head_pkt_q[1];
   assign packet2_o     = head_pkt_q[2];
   assign packet3_o     = head_pkt_q[3];
   assign branchCount_o = head_bc_q;

endmodule

// File: tb/tb_dispatch_skid_buffer.sv
// ============================================================================
// tb_dispatch_skid_buffer
// ----------------------------------------------------------------------------
// Self-checking bench for dispatch_skid_buffer: a directed vector table, a
// few hand-written multi-cycle sequences, and a randomized run checked
// against a queue-based model of the buffer.
// ============================================================================
module tb_dispatch_skid_buffer;

   localparam int PKT_W = 32;
   localparam int BRC_W = 4;

   typedef struct packed {
      logic [3:0][PKT_W-1:0] p;
      logic [BRC_W-1:0]      bc;
   } bundle_t;

   typedef struct {
      logic       rst;
      logic       flush;
      logic       rdy;
      logic       rs;
      int         id;
      logic [3:0] bc;
      logic       ev;
      logic       es;
      int         eid;   // -1: expect all-zero head, -2: head not checked
      logic [3:0] ebc;
   } vec_t;

   logic             clk = 1'b0;
   logic             reset;
   logic             flush_i;
   logic             bufReady_i;
   logic [PKT_W-1:0] bufPacket0_i, bufPacket1_i, bufPacket2_i, bufPacket3_i;
   logic [BRC_W-1:0] bufBranchCount_i;
   logic             bufStall_o;
   logic             renameStall_i;
   logic             valid_o;
   logic [PKT_W-1:0] packet0_o, packet1_o, packet2_o, packet3_o;
   logic [BRC_W-1:0] branchCount_o;
   logic [BRC_W-1:0] freeBranchTags_i;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   dispatch_skid_buffer #(.PKT_W(PKT_W), .BRC_W(BRC_W)) dut (
      .clk              (clk),
      .reset            (reset),
      .flush_i          (flush_i),
      .bufReady_i       (bufReady_i),
      .bufPacket0_i     (bufPacket0_i),
      .bufPacket1_i     (bufPacket1_i),
      .bufPacket2_i     (bufPacket2_i),
      .bufPacket3_i     (bufPacket3_i),
      .bufBranchCount_i (bufBranchCount_i),
      .bufStall_o       (bufStall_o),
      .renameStall_i    (renameStall_i),
      .valid_o          (valid_o),
      .packet0_o        (packet0_o),
      .packet1_o        (packet1_o),
      .packet2_o        (packet2_o),
      .packet3_o        (packet3_o),
`ifdef DISPATCH_BRCHK_EN
      .freeBranchTags_i (freeBranchTags_i),
`endif
      .branchCount_o    (branchCount_o)
   );

   function automatic bundle_t make_bundle(input int id, input logic [BRC_W-1:0] bc);
      bundle_t b;
      for (int k = 0; k < 4; k++) begin
         b.p[k] = 32'hB000_0000 | (PKT_W'(id) << 8) | PKT_W'(k);
      end
      b.bc = bc;
      return b;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_head(input string name, input bundle_t b);
      chk({name, ".pkt0"}, 64'(packet0_o), 64'(b.p[0]));
      chk({name, ".pkt1"}, 64'(packet1_o), 64'(b.p[1]));
      chk({name, ".pkt2"}, 64'(packet2_o), 64'(b.p[2]));
      chk({name, ".pkt3"}, 64'(packet3_o), 64'(b.p[3]));
      chk({name, ".bc"},   64'(branchCount_o), 64'(b.bc));
   endtask

   task automatic drive(input logic rst, input logic fl, input logic rdy,
                        input logic rs, input bundle_t b);
      reset            = rst;
      flush_i          = fl;
      bufReady_i       = rdy;
      renameStall_i    = rs;
      bufPacket0_i     = b.p[0];
      bufPacket1_i     = b.p[1];
      bufPacket2_i     = b.p[2];
      bufPacket3_i     = b.p[3];
      bufBranchCount_i = b.bc;
   endtask

   vec_t    vecs[15];
   bundle_t q[$];
   bundle_t zero_b;
   bundle_t nb;
   logic    r_rst, r_fl, r_rdy, r_rs;
   logic    m_valid, m_stall, m_accept, m_consume, just_reset;

   initial begin
      zero_b = '0;
      freeBranchTags_i = '1;
      drive(1'b1, 1'b0, 1'b0, 1'b0, zero_b);

      //            rst  fl   rdy  rs   id  bc   ev   es   eid ebc
      vecs[0]  = '{1'b1,1'b0,1'b0,1'b0, 0, 4'd0,1'b0,1'b0, -1, 4'd0};
      vecs[1]  = '{1'b0,1'b0,1'b1,1'b0, 1, 4'd2,1'b1,1'b0,  1, 4'd2}; // A in
      vecs[2]  = '{1'b0,1'b0,1'b1,1'b1, 2, 4'd5,1'b1,1'b1,  1, 4'd2}; // B to SKID
      vecs[3]  = '{1'b0,1'b0,1'b1,1'b1, 3, 4'd1,1'b1,1'b1,  1, 4'd2}; // C held
      vecs[4]  = '{1'b0,1'b0,1'b1,1'b0, 3, 4'd1,1'b1,1'b0,  2, 4'd5}; // A out
      vecs[5]  = '{1'b0,1'b0,1'b1,1'b0, 3, 4'd1,1'b1,1'b0,  3, 4'd1}; // B out, C in
      vecs[6]  = '{1'b0,1'b0,1'b0,1'b0, 0, 4'd0,1'b0,1'b0, -2, 4'd0}; // C out
      vecs[7]  = '{1'b0,1'b0,1'b1,1'b1, 4, 4'd3,1'b1,1'b0,  4, 4'd3};
      vecs[8]  = '{1'b0,1'b0,1'b1,1'b1, 5, 4'd0,1'b1,1'b1,  4, 4'd3}; // TWO
      vecs[9]  = '{1'b0,1'b1,1'b1,1'b0, 6, 4'd6,1'b0,1'b0, -2, 4'd0}; // flush
      vecs[10] = '{1'b0,1'b0,1'b0,1'b0, 0, 4'd0,1'b0,1'b0, -2, 4'd0}; // still empty
      vecs[11] = '{1'b0,1'b0,1'b1,1'b1, 7, 4'd7,1'b1,1'b0,  7, 4'd7};
      vecs[12] = '{1'b0,1'b0,1'b1,1'b1, 8, 4'd4,1'b1,1'b1,  7, 4'd7}; // TWO
      vecs[13] = '{1'b1,1'b0,1'b1,1'b1, 9, 4'd9,1'b0,1'b0, -1, 4'd0}; // reset in TWO
      vecs[14] = '{1'b0,1'b0,1'b0,1'b0, 0, 4'd0,1'b0,1'b0, -1, 4'd0};

      @(negedge clk);
      for (int i = 0; i < 15; i++) begin
         drive(vecs[i].rst, vecs[i].flush, vecs[i].rdy, vecs[i].rs,
               make_bundle(vecs[i].id, vecs[i].bc));
         @(negedge clk);
         chk($sformatf("vec%0d.valid", i), 64'(valid_o), 64'(vecs[i].ev));
         chk($sformatf("vec%0d.stall", i), 64'(bufStall_o), 64'(vecs[i].es));
         if (vecs[i].eid == -1)
            chk_head($sformatf("vec%0d.zero", i), zero_b);
         else if (vecs[i].eid >= 0)
            chk_head($sformatf("vec%0d.head", i), make_bundle(vecs[i].eid, vecs[i].ebc));
         $display("[TB] vec %0d: valid=%0b stall=%0b bc=%0d pkt0=%0h",
                  i, valid_o, bufStall_o, branchCount_o, packet0_o);
      end

      // Full throughput: 10 bundles on 10 consecutive cycles, no back-pressure.
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b0, make_bundle(100 + i, BRC_W'(i)));
         @(negedge clk);
         chk($sformatf("tput%0d.valid", i), 64'(valid_o), 64'd1);
         chk($sformatf("tput%0d.stall", i), 64'(bufStall_o), 64'd0);
         chk_head($sformatf("tput%0d", i), make_bundle(100 + i, BRC_W'(i)));
         $display("[TB] tput %0d: pkt0=%0h bc=%0d", i, packet0_o, branchCount_o);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, zero_b);
      @(negedge clk);
      chk("tput.drain", 64'(valid_o), 64'd0);

`ifdef DISPATCH_BRCHK_EN
      // Branch-tag gate: head with 3 branches, only 2 tags free.
      freeBranchTags_i = 4'd2;
      drive(1'b0, 1'b0, 1'b1, 1'b0, make_bundle(50, 4'd3));
      @(negedge clk);
      chk("brchk.blocked", 64'(valid_o), 64'd0);
      chk_head("brchk.head", make_bundle(50, 4'd3));
      drive(1'b0, 1'b0, 1'b0, 1'b0, zero_b);
      @(negedge clk);
      chk("brchk.held", 64'(valid_o), 64'd0);
      chk_head("brchk.held", make_bundle(50, 4'd3));
      freeBranchTags_i = 4'd3;
      #1;
      chk("brchk.release", 64'(valid_o), 64'd1);
      @(negedge clk);
      chk("brchk.consumed", 64'(valid_o), 64'd0);
      $display("[TB] brchk sequence done");
`endif

      // Randomized run against a queue model of the two-entry buffer.
      drive(1'b1, 1'b0, 1'b0, 1'b0, zero_b);
      @(negedge clk);
      q.delete();
      just_reset = 1'b1;
      for (int c = 0; c < 600; c++) begin
         m_valid = (q.size() > 0);
`ifdef DISPATCH_BRCHK_EN
         if (q.size() > 0) m_valid = m_valid && (q[0].bc <= freeBranchTags_i);
`endif
         m_stall = (q.size() == 2);
         chk($sformatf("rnd%0d.valid", c), 64'(valid_o), 64'(m_valid));
         chk($sformatf("rnd%0d.stall", c), 64'(bufStall_o), 64'(m_stall));
         if (q.size() > 0)
            chk_head($sformatf("rnd%0d", c), q[0]);
         else if (just_reset)
            chk_head($sformatf("rnd%0d.zero", c), zero_b);
         $display("[TB] rnd %0d: occ=%0d valid=%0b stall=%0b pkt0=%0h",
                  c, q.size(), valid_o, bufStall_o, packet0_o);

         r_rst = ($urandom_range(99) < 2);
         r_fl  = ($urandom_range(99) < 5);
         r_rdy = ($urandom_range(99) < 70);
         r_rs  = ($urandom_range(99) < 40);
         nb    = make_bundle(1000 + c, BRC_W'($urandom_range(15)));
`ifdef DISPATCH_BRCHK_EN
         freeBranchTags_i = BRC_W'($urandom_range(15));
         m_valid = (q.size() > 0);
         if (q.size() > 0) m_valid = m_valid && (q[0].bc <= freeBranchTags_i);
`endif
         drive(r_rst, r_fl, r_rdy, r_rs, nb);

         m_consume = m_valid && !r_rs;
         m_accept  = r_rdy && !m_stall && !r_fl;
         if (r_rst) begin
            q.delete();
            just_reset = 1'b1;
         end else if (r_fl) begin
            q.delete();
            just_reset = 1'b0;
         end else begin
            if (m_consume) void'(q.pop_front());
            if (m_accept) q.push_back(nb);
            if (m_consume || m_accept) just_reset = 1'b0;
         end
         @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
